// File: rtl/pc_reg_pkg.sv
// Shared constants and address type for the program-counter register.
package pc_reg_pkg;

    localparam int PC_WIDTH      = 64;
    localparam int PC_INCR       = 4;
    localparam int PC_ALIGN_BITS = 2;

    typedef logic [PC_WIDTH-1:0] addr_t;

endpackage : pc_reg_pkg

// File: rtl/pc_reg.sv
// Program-counter register: loads IN every clock outside reset and exposes
// the current PC, its sequential successor, an alignment flag and a valid flag.
module pc_reg
    import pc_reg_pkg::*;
#(
    parameter int               WIDTH       = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               ALIGN_BITS  = PC_ALIGN_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] IN,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] PC_NEXT_SEQ,
    output logic             MISALIGNED,
    output logic             VALID
);

    if (WIDTH <= ALIGN_BITS) begin : g_chk_align
        $error("pc_reg: WIDTH must be greater than ALIGN_BITS");
    end
    if (WIDTH < 3) begin : g_chk_width
        $error("pc_reg: WIDTH must be at least 3");
    end

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             valid_q;
    logic             valid_d;

    always_comb begin
        out_d   = IN;
        valid_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= RESET_VALUE;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign OUT         = out_q;
    assign VALID       = valid_q;
    // Wraps naturally modulo 2^WIDTH.
    assign PC_NEXT_SEQ = out_q + WIDTH'(PC_INCR);

    if (ALIGN_BITS == 0) begin : g_no_align
        assign MISALIGNED = 1'b0;
    end else begin : g_align
        assign MISALIGNED = |out_q[ALIGN_BITS-1:0];
    end

endmodule : pc_reg

// File: tb/tb_pc_reg.sv
// Directed bench for pc_reg: a default 64-bit instance and a 32-bit instance
// with a non-zero reset address share clock and reset.
module tb_pc_reg;
    import pc_reg_pkg::*;

    logic        clk;
    logic        rst;
    addr_t       in64;
    logic [31:0] in32;
    addr_t       out64, nxt64;
    logic [31:0] out32, nxt32;
    logic        mis64, val64, mis32, val32;

    int total = 0;
    int bad   = 0;

    pc_reg dut64 (
        .clk(clk), .rst(rst), .IN(in64), .OUT(out64),
        .PC_NEXT_SEQ(nxt64), .MISALIGNED(mis64), .VALID(val64)
    );

    pc_reg #(.WIDTH(32), .RESET_VALUE(32'h0000_1000)) dut32 (
        .clk(clk), .rst(rst), .IN(in32), .OUT(out32),
        .PC_NEXT_SEQ(nxt32), .MISALIGNED(mis32), .VALID(val32)
    );

    // Posedges at 10, 20, 30 ... ns so reset can be raised at 5 ns.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #20000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
        $display("check %-12s obs=%h exp=%h", tag, obs, exp);
    endtask

    // Drive at the falling edge, sample 1 ns after the following rising edge.
    task automatic load(input logic [63:0] v);
        @(negedge clk);
        in64 = v;
        in32 = v[31:0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b0;
        in64 = '0;
        in32 = '0;

        // Reset hold
        #5 rst = 1'b1;
        #1;
        chk("rst_out", out64, 64'h0);
        chk("rst_valid", {63'b0, val64}, 64'h0);
        chk("rst_next", nxt64, 64'h4);
        chk("rst_mis", {63'b0, mis64}, 64'h0);
        chk("rst_out32", {32'b0, out32}, 64'h0000_1000);
        chk("rst_next32", {32'b0, nxt32}, 64'h0000_1004);
        load(64'hFFFF_FFFF_AAAA_AAAA);
        chk("hold1_out", out64, 64'h0);
        chk("hold1_valid", {63'b0, val64}, 64'h0);
        load(64'hAAAA_AAAA_FFFF_FFFF);
        chk("hold2_out", out64, 64'h0);
        chk("hold2_next", nxt64, 64'h4);
        chk("hold2_out32", {32'b0, out32}, 64'h0000_1000);

        // Load sequence; first load happens on the first edge after release
        @(negedge clk);
        rst  = 1'b0;
        in64 = 64'hFFFF_FFFF_AAAA_AAAA;
        in32 = 32'hAAAA_AAAA;
        chk("pre_out", out64, 64'h0);
        @(posedge clk);
        #1;
        chk("ld1_out", out64, 64'hFFFF_FFFF_AAAA_AAAA);
        chk("ld1_valid", {63'b0, val64}, 64'h1);
        chk("ld1_next", nxt64, 64'hFFFF_FFFF_AAAA_AAAE);
        chk("ld1_mis", {63'b0, mis64}, 64'h1);
        chk("ld1_out32", {32'b0, out32}, 64'hAAAA_AAAA);
        load(64'hAAAA_AAAA_FFFF_FFFF);
        chk("ld2_out", out64, 64'hAAAA_AAAA_FFFF_FFFF);
        chk("ld2_next", nxt64, 64'hAAAA_AAAB_0000_0003);
        load(64'h0);
        chk("ld3_out", out64, 64'h0);
        chk("ld3_mis", {63'b0, mis64}, 64'h0);
        chk("ld3_valid", {63'b0, val64}, 64'h1);
        load(64'hAAAA_AAAA_BBBB_BBBB);
        chk("ld4_out", out64, 64'hAAAA_AAAA_BBBB_BBBB);
        chk("ld4_next", nxt64, 64'hAAAA_AAAA_BBBB_BBBF);
        chk("ld4_mis", {63'b0, mis64}, 64'h1);

        // Asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        chk("arst_out", out64, 64'h0);
        chk("arst_valid", {63'b0, val64}, 64'h0);
        chk("arst_out32", {32'b0, out32}, 64'h0000_1000);
        chk("arst_val32", {63'b0, val32}, 64'h0);

        // Wrap and alignment
        @(negedge clk);
        rst = 1'b0;
        load(64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_out", out64, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_next", nxt64, 64'h0);
        chk("wrap_mis", {63'b0, mis64}, 64'h0);
        chk("wrap_next32", {32'b0, nxt32}, 64'h0);
        chk("wrap_mis32", {63'b0, mis32}, 64'h0);
        load(64'hAAAA_AAAA_FFFF_FFFF);
        chk("mis_flag", {63'b0, mis64}, 64'h1);
        chk("mis_flag32", {63'b0, mis32}, 64'h1);

        // Glitch immunity: IN toggles between edges
        @(negedge clk);
        in64 = 64'h1111_1111_1111_1111;
        #1 in64 = 64'h2222_2222_2222_2222;
        #1 in64 = 64'h0000_0000_0000_3330;
        #1;
        chk("gl_hold", out64, 64'hAAAA_AAAA_FFFF_FFFF);
        @(posedge clk);
        #1;
        chk("gl_edge", out64, 64'h0000_0000_0000_3330);
        in64 = 64'h4444_4444_4444_4444;
        #1 in64 = 64'h5555_5555_5555_5555;
        #1;
        chk("gl_hold2", out64, 64'h0000_0000_0000_3330);
        chk("gl_next", nxt64, 64'h0000_0000_0000_3334);
        @(posedge clk);
        #1;
        chk("gl_edge2", out64, 64'h5555_5555_5555_5555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pc_reg
